// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer driving one outstanding word-wide memory access with ready handshake
//   clk, rst (async, active-high)
//   req_*  : request from datapath (valid/ready, we, byte addr, right-justified wdata, size, unsigned)
//   resp_* : one-cycle completion pulse, extended load data, error flag
//   mem_*  : word-aligned memory port (en held until mem_ready, we, addr, lane-replicated wdata, byte enables)
//   busy   : controller not idle
//   Optional LSU_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES waiting cycles with resp_err=1
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] off_q, size_q;
  logic uns_q, we_q, misaligned, timeout;
  logic [3:0] be_calc;
  logic [31:0] wdata_calc, load_data;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
`ifdef LSU_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] cnt;
  // Fires in the cycle whose stall would bring the count to the limit; a ready in that cycle still wins.
  assign timeout = !mem_ready && cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (state != ACCESS) cnt <= '0;
    else if (!mem_ready) cnt <= cnt + 1'b1;
`else
  wire unused_params = (TIMEOUT_CYCLES > 0) && (CNT_WIDTH > 0);
  assign timeout = 1'b0;
`endif
  always_comb begin
    misaligned = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00) || req_size == 2'b11;
    be_calc = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] : req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_calc = req_size == 2'b00 ? {4{req_wdata[7:0]}} : req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    byte_sel = mem_rdata[8*off_q +: 8];
    half_sel = mem_rdata[16*off_q[1] +: 16];
    load_data = size_q == 2'b00 ? {{24{~uns_q & byte_sel[7]}}, byte_sel} : size_q == 2'b01 ? {{16{~uns_q & half_sel[15]}}, half_sel} : mem_rdata;
    state_nx = state == IDLE ? (req_valid ? (misaligned ? RESP : ACCESS) : IDLE) : state == ACCESS ? ((mem_ready || timeout) ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      we_q <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
    end else begin
      state <= state_nx;
      resp_valid <= 1'b0;
      if (state == IDLE && req_valid) begin
        off_q <= req_addr[1:0];
        size_q <= req_size;
        uns_q <= req_unsigned;
        we_q <= req_we;
        if (misaligned) begin
          resp_valid <= 1'b1;
          resp_err <= 1'b1;
          resp_rdata <= '0;
        end else begin
          mem_en <= 1'b1;
          mem_we <= req_we;
          mem_addr <= {req_addr[31:2], 2'b00};
          mem_be <= be_calc;
          mem_wdata <= wdata_calc;
        end
      end
      if (state == ACCESS && (mem_ready || timeout)) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        resp_valid <= 1'b1;
        resp_err <= !mem_ready;
        resp_rdata <= (mem_ready && !we_q) ? load_data : '0;
      end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, mem_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic [1:0] req_size = '0;
  logic req_ready, resp_valid, resp_err, mem_en, mem_we, busy;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Presents one request while idle; returns in cycle T+1 with req_valid dropped.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz, input logic uns);
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    req_size = sz;
    req_unsigned = uns;
    step();
    req_valid = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({req_ready, busy, resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b busy=%b rv=%b en=%b be=%b exp rdy=1 others 0", req_ready, busy, resp_valid, mem_en, mem_be);
    end
    rst = 1'b0;
    step();
  endtask
  task automatic test_lb();
    issue(1'b0, 32'h1003, 32'h0, 2'b00, 1'b0);
    checks++;
    if ({mem_en, mem_we, mem_be, mem_addr, busy, req_ready} !== {1'b1, 1'b0, 4'b1000, 32'h1000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lb_access got en=%b we=%b be=%b addr=%h exp en=1 we=0 be=1000 addr=00001000", mem_en, mem_we, mem_be, mem_addr);
    end
    mem_rdata = 32'h80112233;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_rdata, mem_en} !== {1'b1, 1'b0, 32'hFFFFFF80, 1'b0}) begin
      errors++;
      $display("FAIL lb_resp got v=%b err=%b rdata=%h en=%b exp v=1 err=0 rdata=ffffff80 en=0", resp_valid, resp_err, resp_rdata, mem_en);
    end
    step();
    checks++;
    if ({resp_valid, req_ready, resp_rdata} !== {1'b0, 1'b1, 32'hFFFFFF80}) begin
      errors++;
      $display("FAIL lb_after got v=%b rdy=%b rdata=%h exp v=0 rdy=1 rdata=ffffff80", resp_valid, req_ready, resp_rdata);
    end
  endtask
  task automatic test_lhu_wait();
    int held = 0;
    issue(1'b0, 32'h2002, 32'h0, 2'b01, 1'b1);
    mem_rdata = 32'hBEEF1234;
    for (int i = 0; i < 3; i++) begin
      if (mem_en && mem_be == 4'b1100 && !resp_valid) held++;
      step();
    end
    checks++;
    if (held !== 3) begin
      errors++;
      $display("FAIL lhu_hold got held=%0d exp 3", held);
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0000BEEF}) begin
      errors++;
      $display("FAIL lhu_resp got v=%b err=%b rdata=%h exp v=1 err=0 rdata=0000beef", resp_valid, resp_err, resp_rdata);
    end
    step();
  endtask
  task automatic test_errors();
    logic [31:0] av[2] = '{32'h4001, 32'h4000};
    logic [1:0] sv[2] = '{2'b10, 2'b11};
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, av[i], 32'h0, sv[i], 1'b0);
      checks++;
      if ({resp_valid, resp_err, resp_rdata, mem_en} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
        errors++;
        $display("FAIL err_resp%0d got v=%b err=%b rdata=%h en=%b exp v=1 err=1 rdata=0 en=0", i, resp_valid, resp_err, resp_rdata, mem_en);
      end
      step();
      checks++;
      if ({resp_valid, req_ready, mem_en, resp_err} !== {1'b0, 1'b1, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL err_after%0d got v=%b rdy=%b en=%b err=%b exp v=0 rdy=1 en=0 err=1", i, resp_valid, req_ready, mem_en, resp_err);
      end
    end
  endtask
  task automatic test_stores();
    logic [31:0] av[2] = '{32'h3002, 32'h4001};
    logic [31:0] dv[2] = '{32'h0000A5C3, 32'h0000005A};
    logic [1:0] sv[2] = '{2'b01, 2'b00};
    logic [3:0] bv[2] = '{4'b1100, 4'b0010};
    logic [31:0] wv[2] = '{32'hA5C3A5C3, 32'h5A5A5A5A};
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, av[i], dv[i], sv[i], 1'b0);
      checks++;
      if ({mem_en, mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 1'b1, bv[i], wv[i], {av[i][31:2], 2'b00}}) begin
        errors++;
        $display("FAIL st%0d_access got en=%b we=%b be=%b wd=%h addr=%h exp be=%b wd=%h", i, mem_en, mem_we, mem_be, mem_wdata, mem_addr, bv[i], wv[i]);
      end
      mem_rdata = 32'hDEADBEEF;
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      checks++;
      if ({resp_valid, resp_err, resp_rdata, mem_en, mem_we} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL st%0d_resp got v=%b err=%b rdata=%h en=%b we=%b exp v=1 err=0 rdata=0", i, resp_valid, resp_err, resp_rdata, mem_en, mem_we);
      end
      step();
    end
  endtask
  task automatic test_load_ext();
    logic [31:0] av[4] = '{32'h6000, 32'h6001, 32'h6004, 32'h6002};
    logic [1:0] sv[4] = '{2'b01, 2'b00, 2'b10, 2'b00};
    logic uv[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] rv[4] = '{32'h00008001, 32'h0000F000, 32'h87654321, 32'h007F0000};
    logic [31:0] ev[4] = '{32'hFFFF8001, 32'h000000F0, 32'h87654321, 32'h0000007F};
    logic [3:0] bv[4] = '{4'b0011, 4'b0010, 4'b1111, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, av[i], 32'h0, sv[i], uv[i]);
      checks++;
      if ({mem_en, mem_be} !== {1'b1, bv[i]}) begin
        errors++;
        $display("FAIL ld%0d_be got en=%b be=%b exp en=1 be=%b", i, mem_en, mem_be, bv[i]);
      end
      mem_rdata = rv[i];
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, ev[i]}) begin
        errors++;
        $display("FAIL ld%0d_resp got v=%b err=%b rdata=%h exp v=1 err=0 rdata=%h", i, resp_valid, resp_err, resp_rdata, ev[i]);
      end
      step();
    end
  endtask
  task automatic test_reset_mid_access();
    int pulses = 0;
    issue(1'b0, 32'h5000, 32'h0, 2'b10, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready, busy, resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL rst_mid got rdy=%b busy=%b rv=%b en=%b addr=%h exp rdy=1 others 0", req_ready, busy, resp_valid, mem_en, mem_addr);
    end
    #2;
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (resp_valid) pulses++;
    end
    mem_ready = 1'b0;
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rst_no_resp got pulses=%0d exp 0", pulses);
    end
    issue(1'b0, 32'h5004, 32'h0, 2'b10, 1'b0);
    mem_rdata = 32'h12345678;
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      errors++;
      $display("FAIL rst_lw_resp got v=%b err=%b rdata=%h exp v=1 err=0 rdata=12345678", resp_valid, resp_err, resp_rdata);
    end
    step();
  endtask
`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int held = 0;
    issue(1'b0, 32'h7000, 32'h0, 2'b10, 1'b0);
    for (int i = 0; i < 15; i++) begin
      if (mem_en && !resp_valid) held++;
      step();
    end
    checks++;
    if ({held, mem_en, mem_we, resp_valid, resp_err, resp_rdata} !== {32'd15, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL timeout got held=%0d en=%b v=%b err=%b rdata=%h exp held=15 en=0 v=1 err=1 rdata=0", held, mem_en, resp_valid, resp_err, resp_rdata);
    end
    step();
    issue(1'b0, 32'h7004, 32'h0, 2'b10, 1'b0);
    mem_rdata = 32'hCAFEF00D;
    repeat (14) step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL timeout_edge got v=%b err=%b rdata=%h exp v=1 err=0 rdata=cafef00d", resp_valid, resp_err, resp_rdata);
    end
    step();
  endtask
`else
  task automatic test_long_wait();
    int held = 0;
    issue(1'b0, 32'h7000, 32'h0, 2'b10, 1'b0);
    mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 20; i++) begin
      if (mem_en && !resp_valid) held++;
      step();
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++;
    if ({held, resp_valid, resp_err, resp_rdata} !== {32'd20, 1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL long_wait got held=%0d v=%b err=%b rdata=%h exp held=20 v=1 err=0 rdata=cafef00d", held, resp_valid, resp_err, resp_rdata);
    end
    step();
  endtask
`endif
  task automatic test_idle_ready_ignored();
    mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    checks++;
    if ({resp_valid, mem_en, req_ready} !== {1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL idle_ready got v=%b en=%b rdy=%b exp v=0 en=0 rdy=1", resp_valid, mem_en, req_ready);
    end
  endtask
  initial begin
    test_reset();
    test_lb();
    test_lhu_wait();
    test_errors();
    test_stores();
    test_load_ext();
    test_reset_mid_access();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_idle_ready_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
